// File: rtl/tb_memory_regbus.sv
// Register-bus word memory with byte strobes, range checking and async reset clear.
// Optional one-wait-state handshake: define TB_MEMORY_REGBUS_WAIT_EN.
package tb_memory_regbus_pkg;
  typedef struct packed {
    logic [47:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } rsp_t;
endpackage

module tb_memory_regbus #(
  parameter int unsigned          AddrWidth = 48,
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          NumWords  = 1024,
  parameter logic [AddrWidth-1:0] BaseAddr  = '0,
  parameter type                  req_t     = tb_memory_regbus_pkg::req_t,
  parameter type                  rsp_t     = tb_memory_regbus_pkg::rsp_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  req_t req_i,
  output rsp_t rsp_o
);
  localparam int unsigned          NumLanes  = DataWidth / 8;
  localparam int unsigned          OffBits   = $clog2(NumLanes);
  localparam int unsigned          IdxWidth  = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam logic [AddrWidth-1:0] WordLimit = AddrWidth'(NumWords);

  logic [AddrWidth-1:0] offset;
  logic [AddrWidth-1:0] word_idx;
  logic [IdxWidth-1:0]  mem_idx;
  logic                 in_range;
  logic                 ready;
  logic                 do_write;
  logic [DataWidth-1:0] wmask;
  logic [DataWidth-1:0] mem [NumWords];

  // The >= test keeps addresses below the base from wrapping into range.
  assign offset   = req_i.addr - BaseAddr;
  assign word_idx = offset >> OffBits;
  assign mem_idx  = word_idx[IdxWidth-1:0];
  assign in_range = (req_i.addr >= BaseAddr) && (word_idx < WordLimit);

  for (genvar gi = 0; gi < NumLanes; gi++) begin : g_lane
    assign wmask[gi*8 +: 8] = {8{req_i.wstrb[gi]}};
  end

`ifdef TB_MEMORY_REGBUS_WAIT_EN
  logic pending;

  // First cycle of each request arms pending; the completing edge or an idle cycle clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending <= 1'b0;
    end else if (!req_i.valid || pending) begin
      pending <= 1'b0;
    end else begin
      pending <= 1'b1;
    end
  end

  assign ready = req_i.valid & pending;
`else
  assign ready = req_i.valid;
`endif

  assign do_write = ready && req_i.write && in_range;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumWords); i++) begin
        mem[i] <= '0;
      end
    end else if (do_write) begin
      mem[mem_idx] <= (mem[mem_idx] & ~wmask) | (req_i.wdata & wmask);
    end
  end

  always_comb begin
    rsp_o       = '0;
    rsp_o.ready = ready;
    if (ready) begin
      rsp_o.error = ~in_range;
      if (in_range && !req_i.write) begin
        rsp_o.rdata = mem[mem_idx];
      end
    end
  end
endmodule

// File: tb/tb_tb_memory_regbus.sv
// Self-checking bench: byte-level reference memory compared every cycle, plus literal
// directed checks and a randomized transaction phase.
module tb_tb_memory_regbus;
  import tb_memory_regbus_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  req_t req   = '0;
  rsp_t rsp;
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef TB_MEMORY_REGBUS_WAIT_EN
  localparam int Lat    = 2;
  localparam bit WaitEn = 1'b1;
`else
  localparam int Lat    = 1;
  localparam bit WaitEn = 1'b0;
`endif

  always #5 clk = ~clk;

  tb_memory_regbus #(
    .AddrWidth(48),
    .DataWidth(32),
    .NumWords (1024),
    .BaseAddr (48'h0),
    .req_t    (req_t),
    .rsp_t    (rsp_t)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .req_i (req),
    .rsp_o (rsp)
  );

  // Reference: 4096 bytes, byte address = bus address (base 0).
  logic [7:0] bmem [4096];
  bit         waited;

  function automatic bit m_in_range(logic [47:0] a);
    return a < 48'd4096;
  endfunction

  function automatic logic [31:0] m_word(logic [47:0] a);
    int b;
    b = int'(a[11:0]) & ~3;
    return {bmem[b+3], bmem[b+2], bmem[b+1], bmem[b]};
  endfunction

  function automatic bit m_ready();
    return req.valid && (!WaitEn || waited);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4096; i++) bmem[i] <= 8'h00;
      waited <= 1'b0;
    end else begin
      if (m_ready() && req.write && m_in_range(req.addr)) begin
        for (int l = 0; l < 4; l++) begin
          if (req.wstrb[l]) bmem[(int'(req.addr[11:0]) & ~3) + l] <= req.wdata[8*l +: 8];
        end
      end
      waited <= req.valid && !m_ready();
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit r;
    r = m_ready();
    chk("ready", 64'(rsp.ready), 64'(r));
    chk("error", 64'(rsp.error), 64'(r && !m_in_range(req.addr)));
    if (!req.write || !r)
      chk("rdata", 64'(rsp.rdata), (r && m_in_range(req.addr)) ? 64'(m_word(req.addr)) : 64'd0);
  end

  task automatic xfer(input bit w, input logic [47:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic er, output int cyc);
    bit done;
    done = 1'b0;
    req.valid = 1'b1; req.write = w; req.addr = a; req.wdata = d; req.wstrb = s;
    cyc = 0; rd = '0; er = 1'b0;
    while (!done && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (rsp.ready) begin
        rd = rsp.rdata; er = rsp.error; done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: no ready after %0d cycles addr=%h", cyc, a);
    end
    req.valid = 1'b0;
    $display("xfer %s addr=%h wdata=%h wstrb=%h -> rdata=%h error=%0d cycles=%0d",
             w ? "WR" : "RD", a, d, s, rd, er, cyc);
  endtask

  task automatic rd_chk(input string name, input logic [47:0] a, input logic [31:0] exp_d,
                        input logic exp_e);
    logic [31:0] rd; logic er; int cyc;
    xfer(1'b0, a, 32'h0, 4'h0, rd, er, cyc);
    chk({name, "_rdata"}, 64'(rd), 64'(exp_d));
    chk({name, "_error"}, 64'(er), 64'(exp_e));
    chk({name, "_cycles"}, 64'(cyc), 64'(Lat));
  endtask

  task automatic wr_chk(input string name, input logic [47:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic exp_e);
    logic [31:0] rd; logic er; int cyc;
    xfer(1'b1, a, d, s, rd, er, cyc);
    chk({name, "_error"}, 64'(er), 64'(exp_e));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd; logic er; int cyc; int sel; logic [47:0] a;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    rd_chk("rd0_after_reset", 48'h0, 32'h0000_0000, 1'b0);
    wr_chk("wr10", 48'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
    rd_chk("rd10", 48'h10, 32'hDEAD_BEEF, 1'b0);
    rd_chk("rd13", 48'h13, 32'hDEAD_BEEF, 1'b0);
    wr_chk("wr10_strb5", 48'h10, 32'h1122_3344, 4'h5, 1'b0);
    rd_chk("rd10_merged", 48'h10, 32'hDE22_BE44, 1'b0);
    wr_chk("wr10_strb0", 48'h10, 32'hFFFF_FFFF, 4'h0, 1'b0);
    rd_chk("rd10_nostrb", 48'h10, 32'hDE22_BE44, 1'b0);
    rd_chk("rd1000_oor", 48'h1000, 32'h0, 1'b1);
    wr_chk("wr1000_oor", 48'h1000, 32'h1234_5678, 4'hF, 1'b1);
    rd_chk("rd0_noalias", 48'h0, 32'h0, 1'b0);
    rd_chk("rd_top_oor", 48'hFFFF_FFFF_FFFC, 32'h0, 1'b1);
    rd_chk("rd_last_word", 48'hFFC, 32'h0, 1'b0);

    // Reset in the middle of a write cycle: the write must not land.
    wr_chk("wr10_again", 48'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
    req.valid = 1'b1; req.write = 1'b1; req.addr = 48'h10; req.wdata = 32'hCAFE_F00D; req.wstrb = 4'hF;
    #2 rst_n = 1'b0;
    req.valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    rd_chk("rd10_after_midreset", 48'h10, 32'h0000_0000, 1'b0);

`ifdef TB_MEMORY_REGBUS_WAIT_EN
    wr_chk("wr10_wait", 48'h10, 32'h0BAD_F00D, 4'hF, 1'b0);
    req.valid = 1'b1; req.write = 1'b0; req.addr = 48'h10;
    @(negedge clk) chk("wait_c1_ready", 64'(rsp.ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk) begin
      chk("wait_c2_ready", 64'(rsp.ready), 64'd1);
      chk("wait_c2_rdata", 64'(rsp.rdata), 64'h0BAD_F00D);
    end
    @(posedge clk); #1 req.valid = 1'b0;
    @(posedge clk); #1 req.valid = 1'b1;
    @(negedge clk) chk("abort_c1_ready", 64'(rsp.ready), 64'd0);
    @(posedge clk); #1 req.valid = 1'b0;
    @(posedge clk); #1 req.valid = 1'b1;
    @(negedge clk) chk("fresh_c1_ready", 64'(rsp.ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk) chk("fresh_c2_ready", 64'(rsp.ready), 64'd1);
    @(posedge clk); #1 req.valid = 1'b0;
`endif

    for (int t = 0; t < 300; t++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 70)      a = 48'($urandom_range(0, 63));
      else if (sel < 85) a = 48'h1000 + 48'($urandom_range(0, 15)) - 48'd8;
      else               a = {16'($urandom), 32'($urandom)};
      xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), rd, er, cyc);
      chk("rand_cycles", 64'(cyc), 64'(Lat));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tb_memory_regbus.md
TB_MEMORY_REGBUS -- requirements
Module: tb_memory_regbus

Interface
REQ-001 SHALL have parameter AddrWidth, default 48, register-bus address width in bits.
REQ-002 SHALL have parameter DataWidth, default 32, data width in bits; multiple of 8 and a power of two.
REQ-003 SHALL have parameter NumWords, default 1024, memory depth in DataWidth-bit words.
REQ-004 SHALL have parameter BaseAddr, default 0, byte address of word 0.
REQ-005 SHALL have type parameters req_t and rsp_t, the register-bus request and response structs.
REQ-006 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-007 rst_ni  input  1  reset, asynchronous, active-low.
REQ-008 req_i  input  req_t  fields addr[AddrWidth], write, wdata[DataWidth], wstrb[DataWidth/8], valid.
REQ-009 rsp_o  output  rsp_t  fields rdata[DataWidth], error, ready.

Function
REQ-010 SHALL hold NumWords x DataWidth storage.
REQ-011 Word index SHALL be (addr - BaseAddr) >> log2(DataWidth/8); address LSBs below word granularity SHALL be ignored.
REQ-012 Access SHALL be in range when addr >= BaseAddr and index < NumWords; otherwise out of range.
REQ-013 Transfer SHALL complete in the cycle where valid and ready are both high.
REQ-014 Default (no wait states): ready SHALL equal valid combinationally; every request completes in its first cycle.
REQ-015 Read in range: rdata SHALL be the stored word at the index, combinationally, during the completing cycle; error=0.
REQ-016 Write in range: on the completing rising edge, each byte lane i with wstrb[i]=1 SHALL be updated from wdata; lanes with wstrb[i]=0 unchanged; error=0.
REQ-017 Write with wstrb all zero SHALL complete with error=0 and change no storage.
REQ-018 Out-of-range access SHALL complete with error=1 and rdata=0; writes SHALL not modify storage.
REQ-019 When valid=0: ready=0, error=0, rdata=0.
REQ-020 A read and write to the same word in consecutive cycles SHALL return the newly written data on the read.
REQ-021 Subtraction and index arithmetic SHALL use AddrWidth bits; addr below BaseAddr SHALL not wrap into range.

Reset
REQ-022 While rst_ni=0, all storage words SHALL be 0 and the wait-state flag (REQ-024) SHALL be 0.
REQ-023 Reset asserted mid-transfer SHALL abort it with no storage update; first request after release starts fresh.

Configuration
REQ-024 Macro TB_MEMORY_REGBUS_WAIT_EN defined: one wait state per transfer; internal flag pending set on rising edge when valid=1 and pending=0; ready=valid and pending; pending cleared on the edge a transfer completes or when valid=0; ready=0 in first cycle of every request, rdata/error valid only while ready=1 (0 otherwise).
REQ-025 Macro TB_MEMORY_REGBUS_WAIT_EN undefined: no pending flag; REQ-014 behaviour.
REQ-026 Back-to-back requests with macro defined SHALL each take exactly 2 cycles (valid held high across both).

Verification
REQ-027 Reset, then read addr 0x0 -> ready=1 same cycle, rdata=0x00000000, error=0.
REQ-028 Write addr 0x10 wdata 0xDEADBEEF wstrb 0xF, then read 0x10 -> rdata=0xDEADBEEF; read 0x13 -> rdata=0xDEADBEEF.
REQ-029 After REQ-028, write 0x10 wdata 0x11223344 wstrb 0x5, read 0x10 -> rdata=0xDE22BE44.
REQ-030 Read and write at addr 0x1000 (NumWords=1024, DataWidth=32) -> error=1, rdata=0; subsequent read 0x0 returns 0 (no aliasing).
REQ-031 Assert rst_ni=0 after REQ-028 mid-cycle -> read 0x10 after release returns 0x00000000.
REQ-032 TB_MEMORY_REGBUS_WAIT_EN defined, hold valid on read of 0x10 -> ready=0 cycle 1, ready=1 cycle 2 with correct rdata; dropping valid after cycle 1 leaves no pending state.
